// File: rtl/fifo_serial_tx.sv
// Purpose : pops words from a register FIFO and sends each as a start/data(LSB first)/stop serial frame.
// Latency : tx drops on the pop edge; a frame takes (WIDTH+2)*CLKS_PER_BIT cycles, with the next pop possible in the first idle cycle.
// Backpress: pops only when idle and the FIFO is non-empty; otherwise the line idles high indefinitely.
module fifo_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_out,
  output logic             fifo_shift_out,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             tx_q, tx_n;
  logic             done_q, done_n;
  logic             bit_end;
  logic             last_bit;

  // A bit period ends when the timer reaches its last count; with one
  // clock per bit this is always true and the timer never moves off zero.
  assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));
  assign last_bit = (idx == IW'(WIDTH - 1));

  // Pop only from idle, and never while reset is held, so a word is never
  // removed from the FIFO that the frame logic would then throw away.
  assign fifo_shift_out = (state == IDLE) & ~fifo_empty & ~res;
  assign busy           = (state != IDLE);
  assign tx             = tx_q;
  assign frame_done     = done_q;

  // State and datapath registers; reset forces the line high immediately.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      shreg  <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      tx_q   <= tx_n;
      done_q <= done_n;
    end
  end

  // Next-state logic; tx_n is the level of the bit being entered, so the
  // registered line changes exactly on the edge that starts each bit.
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (fifo_shift_out) begin
          shreg_n = fifo_out;
          timer_n = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_n = '0;
          idx_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_n = '0;
          shreg_n = shreg >> 1;
          if (last_bit) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            idx_n = idx + 1'b1;
            tx_n  = shreg_n[0];
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          tx_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
